// File: rtl/pwm_pkg.sv
// pwm_pkg: shared sizes and the edge record for the PWM generator.
//   WIDTH      : bit width of cycle, time and edge values
//   DEPTH      : number of transducer channels
//   pwm_edge_t : {over, left, right} edge set for one channel
package pwm_pkg;
  localparam int WIDTH = 13;
  localparam int DEPTH = 249;

  typedef struct packed {
    logic             over;
    logic [WIDTH-1:0] left;
    logic [WIDTH-1:0] right;
  } pwm_edge_t;
endpackage

// File: rtl/pwm_channel.sv
// pwm_channel: one transducer channel. It has a free-running period counter,
// double-buffered (pending/active) edges and a registered window compare.
//   CLK, RST : clock, async active-high reset
//   update   : capture edge_in into pending and set the pending flag
//   sync     : restart the counter; also a transfer point for pending edges
//   cycle    : period in clocks (values below 2 wrap every clock)
//   edge_in  : incoming {over, left, right}
//   pwm_out  : registered PWM bit. Latency is 1 clock, or 2 clocks with
//              PWM_OUT_REG_EN defined.
import pwm_pkg::*;

module pwm_channel (
  input  logic             CLK,
  input  logic             RST,
  input  logic             update,
  input  logic             sync,
  input  logic [WIDTH-1:0] cycle,
  input  pwm_edge_t        edge_in,
  output logic             pwm_out
);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  localparam logic [WIDTH-1:0] TWO = WIDTH'(2);

  logic [WIDTH-1:0] t;
  logic [WIDTH-1:0] cyc_m1;
  pwm_edge_t        pend, act;
  logic             pflag, bnd, hit, pwm_q;

  // A boundary is also taken when cycle shrinks below the current t.
  assign cyc_m1 = cycle - ONE;
  assign bnd    = sync | (cycle < TWO) | (t >= cyc_m1);

  // A wrapped window (over=1) is the union of the head and the tail of the period.
  always_comb begin
    if (act.over) hit = (t < act.right) | (act.left <= t);
    else          hit = (act.left <= t) & (t < act.right);
  end

  // The transfer reads the old pending value. A capture in the same cycle
  // leaves its data pending until the next boundary.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      t     <= '0;
      pend  <= '0;
      act   <= '0;
      pflag <= 1'b0;
      pwm_q <= 1'b0;
    end else begin
      t     <= bnd ? '0 : t + ONE;
      pwm_q <= hit;
      if (bnd && pflag) act <= pend;
      if (update) begin
        pend  <= edge_in;
        pflag <= 1'b1;
      end else if (bnd) begin
        pflag <= 1'b0;
      end
    end
  end

`ifdef PWM_OUT_REG_EN
  logic pwm_q2;
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) pwm_q2 <= 1'b0;
    else     pwm_q2 <= pwm_q;
  end
  assign pwm_out = pwm_q2;
`else
  assign pwm_out = pwm_q;
`endif
endmodule

// File: rtl/pwm_generator.sv
// pwm_generator: DEPTH independent PWM channels that share the UPDATE and
// SYNC strobes. Optional macro PWM_OUT_REG_EN adds a second output register
// to each channel, which gives 2-clock latency.
//   CLK, RST : clock, async active-high reset
//   UPDATE   : capture LEFT/RIGHT/OVER for all channels into pending
//   SYNC     : restart all channel time counters
//   CYCLE    : period per channel
//   OVER     : wrap flag per channel
//   LEFT     : rising-edge time per channel
//   RIGHT    : falling-edge time per channel
//   PWM_OUT  : PWM output per channel
import pwm_pkg::*;

module pwm_generator #(
  parameter int WIDTH = pwm_pkg::WIDTH,
  parameter int DEPTH = pwm_pkg::DEPTH
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        UPDATE,
  input  logic                        SYNC,
  input  logic [DEPTH-1:0][WIDTH-1:0] CYCLE,
  input  logic [DEPTH-1:0]            OVER,
  input  logic [DEPTH-1:0][WIDTH-1:0] LEFT,
  input  logic [DEPTH-1:0][WIDTH-1:0] RIGHT,
  output logic [DEPTH-1:0]            PWM_OUT
);
  for (genvar g = 0; g < DEPTH; g++) begin : g_ch
    pwm_edge_t e;
    assign e = '{over: OVER[g], left: LEFT[g], right: RIGHT[g]};

    pwm_channel u_ch (
      .CLK     (CLK),
      .RST     (RST),
      .update  (UPDATE),
      .sync    (SYNC),
      .cycle   (CYCLE[g]),
      .edge_in (e),
      .pwm_out (PWM_OUT[g])
    );
  end
endmodule

// File: doc/pwm_generator.md
Name: pwm_generator

Overview:
- Consumer end of the PWM preconditioning path. Takes per-transducer LEFT/RIGHT/OVER edge positions and per-transducer CYCLE, and drives one PWM output bit per transducer.
- Holds a double-buffered (pending/active) copy of the edges. Pending values become active only at each channel's period boundary, so a waveform never glitches mid-period.
- Sits between the preconditioner and the transducer output pins.

Parameters:
- WIDTH, 13, bit width of cycle, time and edge values
- DEPTH, 249, number of transducer channels

Ports:
- CLK  input  1  system clock, all logic on rising edge
- RST  input  1  asynchronous, active-high reset
- UPDATE  input  1  one-cycle strobe; LEFT/RIGHT/OVER are valid this cycle and are captured
- SYNC  input  1  one-cycle strobe; restarts all channel time counters
- CYCLE  input  [WIDTH-1:0] x DEPTH  period per channel, in clocks
- OVER  input  1 x DEPTH  wrap flag from the preconditioner
- LEFT  input  [WIDTH-1:0] x DEPTH  rising-edge time
- RIGHT  input  [WIDTH-1:0] x DEPTH  falling-edge time
- PWM_OUT  output  1 x DEPTH  PWM output per channel

Behaviour:
- Reset (async, RST=1): per channel, t=0, active {over,left,right}={0,0,0}, pending flag=0, pending regs=0, PWM_OUT=0. All state held while RST=1.
- Time counter t, per channel, unsigned WIDTH bits:
  - SYNC=1: next t=0.
  - Else if t >= CYCLE-1, or CYCLE<2: next t=0. This is the boundary; it also covers a CYCLE shrink below the current t.
  - Else: next t=t+1.
- Capture: UPDATE=1 loads all DEPTH pending regs from LEFT/RIGHT/OVER and sets every pending flag.
  - UPDATE with a flag already set overwrites the pending values; last UPDATE wins.
- Transfer: on a boundary cycle or a SYNC cycle with pending flag=1, active<=pending and the flag clears.
- Same-cycle UPDATE and boundary: the transfer uses the old pending contents. The new capture stays pending until the next boundary (no bypass).
  - If the flag was 0 before, the new data waits one full period.
- Compare, using active values and current t:
  - over=0: hit = (left <= t) && (t < right). left==right gives a constant 0.
  - over=1: hit = (t < right) || (left <= t).
- PWM_OUT is registered: PWM_OUT in cycle n+1 equals hit for t of cycle n. Latency is 1 clock.
- Fixed timing after UPDATE: new edges take effect for the period that starts after the next boundary, no earlier.
- All compares unsigned, WIDTH bits. Left/right >= CYCLE are legal and simply never (or always) match per the formulas.

Optional Feature:
- PWM_OUT_REG_EN defined: adds a second output register stage per channel for I/O timing. Latency is 2 clocks; reset value 0.
- Undefined: single register, latency 1 clock.

Decomposition:
- Package pwm_pkg holds:
  - localparams WIDTH=13, DEPTH=249
  - typedef pwm_edge_t = packed struct {over, left[WIDTH-1:0], right[WIDTH-1:0]}
- Sub-module pwm_channel: one channel's counter, pending/active registers and compare. Instantiated DEPTH times in a generate loop; the top distributes UPDATE/SYNC.

Test Plan:
- Reset then CYCLE=4096, no UPDATE -> PWM_OUT=0 for 3 full periods on all channels.
- CYCLE=4096, UPDATE {over=0, left=1000, right=3000}, then SYNC -> each period, PWM_OUT high exactly while t in 1000..2999 (2000 clocks, seen 1 clock later). With PWM_OUT_REG_EN, shifted one more clock.
- CYCLE=4096, UPDATE {over=1, left=3000, right=1000} -> high for t<1000 or t>=3000 (2096 clocks per period). left=right=0 with over=1 -> constantly high.
- UPDATE mid-period at t=2000 with new {0, 100, 200} -> old waveform completes to t=4095; new edges from the next t=0.
  - Second UPDATE {0, 300, 400} before the boundary -> only 300..399 ever appears.
- UPDATE asserted exactly when t=4095 on a channel with flag=0 -> the following period still uses old edges; new edges apply from the period after.
- SYNC at t=1500 with a pending update -> t restarts at 0 next cycle and pending applies immediately.
  - CYCLE reduced 4096->1000 while t=2500 -> wraps to 0 next cycle.
  - RST asserted mid-period -> PWM_OUT=0 asynchronously.
